// File: rtl/mean_sched_pkg.sv
// Shared types for the mean_unit job scheduler: FSM state encoding, data width
// and the packed layout of the job parameter word.
package mean_sched_pkg;

   localparam int DATA_W       = 32;
   localparam int PARAM_DIMS_W = 16;
   localparam int PARAM_AXES_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   // dims occupies bits [31:16], axes occupies bits [15:0]
   typedef struct packed {
      logic [PARAM_DIMS_W-1:0] dims;
      logic [PARAM_AXES_W-1:0] axes;
   } params_t;

endpackage

// File: rtl/mean_job_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant plus encoded id, searching
// upward from ptr_i and wrapping. The owner keeps the pointer register.
module rr_arbiter #(
   parameter int  NUM_REQ = 4,
   localparam int RID_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [RID_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [RID_W-1:0]   grant_id_o,
   output logic               grant_valid_o
);

   logic found;

   // First pass covers ptr..NUM_REQ-1, second pass wraps to 0..ptr-1.
   always_comb begin
      grant_o       = '0;
      grant_id_o    = '0;
      found         = 1'b0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!found && req_i[j] && (j >= int'(ptr_i))) begin
            grant_o[j] = 1'b1;
            grant_id_o = RID_W'(j);
            found      = 1'b1;
         end
      end
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!found && req_i[j] && (j < int'(ptr_i))) begin
            grant_o[j] = 1'b1;
            grant_id_o = RID_W'(j);
            found      = 1'b1;
         end
      end
      grant_valid_o = found;
   end

endmodule

// File: rtl/mean_job_scheduler.sv
// Shares one mean_unit between NUM_REQ requesters, one job at a time.
// Optional WAIT watchdog enabled by defining MEAN_SCHED_TIMEOUT_EN.
module mean_job_scheduler
   import mean_sched_pkg::*;
#(
   parameter int  NUM_REQ        = 4,
   parameter int  TIMEOUT_CYCLES = 1024,
   localparam int RID_W          = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_ptr,
   input  logic [NUM_REQ*DATA_W-1:0] req_params,
   output logic                      unit_start,
   output logic [DATA_W-1:0]         unit_input_ptr,
   output logic [DATA_W-1:0]         unit_params,
   input  logic                      unit_ready,
   input  logic                      unit_done,
   input  logic [DATA_W-1:0]         unit_result,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [RID_W-1:0]          rsp_id,
   output logic [DATA_W-1:0]         rsp_result,
   output logic                      rsp_err,
   output logic                      busy
);

   state_e             state_q, state_d;
   logic [RID_W-1:0]   rrPtr_q, rrPtr_d;
   logic [RID_W-1:0]   id_q, id_d;
   logic [DATA_W-1:0]  inPtr_q, inPtr_d;
   params_t            params_q, params_d;
   logic [DATA_W-1:0]  result_q, result_d;

   logic [NUM_REQ-1:0] grant;
   logic [RID_W-1:0]   grantId;
   logic               grantValid;
   logic [DATA_W-1:0]  selPtr;
   params_t            selParams;
   logic               timeoutHit;
   logic               driveUnit;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req_i        (req_valid),
      .ptr_i        (rrPtr_q),
      .grant_o      (grant),
      .grant_id_o   (grantId),
      .grant_valid_o(grantValid)
   );

   // Grant is one-hot, so an OR-style mux picks the winner's slices.
   always_comb begin
      selPtr    = '0;
      selParams = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            selPtr    = req_ptr[DATA_W*i +: DATA_W];
            selParams = params_t'(req_params[DATA_W*i +: DATA_W]);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      rrPtr_d  = rrPtr_q;
      id_d     = id_q;
      inPtr_d  = inPtr_q;
      params_d = params_q;
      result_d = result_q;
      case (state_q)
         ST_IDLE: begin
            if (grantValid) begin
               id_d     = grantId;
               inPtr_d  = selPtr;
               params_d = selParams;
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (unit_ready) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (unit_done) begin
               result_d = unit_result;
               state_d  = ST_RESP;
            end else if (timeoutHit) begin
               result_d = '0;
               state_d  = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rrPtr_d = (id_q == RID_W'(NUM_REQ - 1)) ? '0 : id_q + RID_W'(1);
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         rrPtr_q  <= '0;
         id_q     <= '0;
         inPtr_q  <= '0;
         params_q <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         rrPtr_q  <= rrPtr_d;
         id_q     <= id_d;
         inPtr_q  <= inPtr_d;
         params_q <= params_d;
         result_q <= result_d;
      end
   end

`ifdef MEAN_SCHED_TIMEOUT_EN
   logic [31:0] waitCnt_q, waitCnt_d;
   logic        err_q, err_d;

   // Counter is zeroed while in ISSUE so it starts at 0 on the first WAIT cycle.
   assign timeoutHit = (state_q == ST_WAIT) && (waitCnt_q == 32'(TIMEOUT_CYCLES - 1));

   always_comb begin
      waitCnt_d = waitCnt_q;
      err_d     = err_q;
      if (state_q == ST_ISSUE) begin
         waitCnt_d = '0;
         err_d     = 1'b0;
      end else if (state_q == ST_WAIT) begin
         waitCnt_d = waitCnt_q + 32'd1;
         if (unit_done)       err_d = 1'b0;
         else if (timeoutHit) err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         waitCnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         waitCnt_q <= waitCnt_d;
         err_q     <= err_d;
      end
   end

   assign rsp_err = err_q;
`else
   logic unusedTimeout;
   assign unusedTimeout = (TIMEOUT_CYCLES == 0);
   assign timeoutHit    = 1'b0;
   assign rsp_err       = 1'b0;
`endif

   assign driveUnit      = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
   assign req_ready      = ((state_q == ST_IDLE) && rst_n) ? grant : '0;
   assign unit_start     = (state_q == ST_ISSUE) && unit_ready;
   assign unit_input_ptr = driveUnit ? inPtr_q : '0;
   assign unit_params    = driveUnit ? params_q : '0;
   assign rsp_valid      = (state_q == ST_RESP);
   assign rsp_id         = id_q;
   assign rsp_result     = result_q;
   assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mean_job_scheduler.sv
// Scoreboard bench for mean_job_scheduler with a behavioural mean_unit model;
// define MEAN_SCHED_TIMEOUT_EN to exercise the watchdog path.
module tb_mean_job_scheduler;

   localparam int NUM_REQ = 4;
   localparam int RID_W   = 2;

   typedef struct packed {
      logic [RID_W-1:0] id;
      logic [31:0]      result;
      logic             err;
   } rsp_t;

   logic                 clk;
   logic                 rst_n;
   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ-1:0]   req_ready;
   logic [NUM_REQ*32-1:0] req_ptr;
   logic [NUM_REQ*32-1:0] req_params;
   logic                 unit_start;
   logic [31:0]          unit_input_ptr;
   logic [31:0]          unit_params;
   logic                 unit_ready;
   logic                 unit_done;
   logic [31:0]          unit_result;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [RID_W-1:0]     rsp_id;
   logic [31:0]          rsp_result;
   logic                 rsp_err;
   logic                 busy;

   rsp_t        rspQ[$];
   logic [31:0] startQ[$];
   int          assertCount = 0;
   int          failCount   = 0;
   int          startCount  = 0;
   int          modelDelay  = 5;
   logic        modelRespond = 1'b1;

   mean_job_scheduler #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_ptr       (req_ptr),
      .req_params    (req_params),
      .unit_start    (unit_start),
      .unit_input_ptr(unit_input_ptr),
      .unit_params   (unit_params),
      .unit_ready    (unit_ready),
      .unit_done     (unit_done),
      .unit_result   (unit_result),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_id        (rsp_id),
      .rsp_result    (rsp_result),
      .rsp_err       (rsp_err),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [NUM_REQ-1:0] valid);
      req_valid = valid;
   endtask

   task automatic waitIdle(input int maxCycles);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < maxCycles);
      checkOutput("idle_reached", {31'b0, !busy}, 32'd1);
   endtask

   task automatic waitRsp(input int maxCycles);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rsp_valid && n < maxCycles);
      checkOutput("rsp_valid_reached", {31'b0, rsp_valid}, 32'd1);
   endtask

   task automatic doReset();
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // mean_unit model: result is the job pointer divided by 0x1000.
   initial begin
      logic [31:0] capture;
      unit_done   = 1'b0;
      unit_result = '0;
      forever begin
         @(negedge clk);
         if (unit_start) begin
            startCount++;
            capture = unit_input_ptr;
            if (startQ.size() == 0) checkOutput("start_unexpected", 32'd1, 32'd0);
            else                    checkOutput("unit_input_ptr", capture, startQ.pop_front());
            if (modelRespond) begin
               repeat (modelDelay) @(negedge clk);
               unit_done   = 1'b1;
               unit_result = capture >> 12;
               @(negedge clk);
               unit_done   = 1'b0;
               unit_result = '0;
            end
         end
      end
   end

   // Response monitor: every completed handshake is matched against the scoreboard.
   initial begin
      rsp_t exp;
      forever begin
         @(negedge clk);
         if (rst_n && rsp_valid && rsp_ready) begin
            if (rspQ.size() == 0) begin
               checkOutput("rsp_unexpected", 32'd1, 32'd0);
            end else begin
               exp = rspQ.pop_front();
               checkOutput("rsp_id", 32'(rsp_id), 32'(exp.id));
               checkOutput("rsp_result", rsp_result, exp.result);
               checkOutput("rsp_err", {31'b0, rsp_err}, {31'b0, exp.err});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [NUM_REQ-1:0] order [5];
      int accepts;
      int n;
      order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

      rst_n      = 1'b0;
      req_ptr    = {32'h4000, 32'h3000, 32'h2000, 32'h1000};
      req_params = {4{32'h0002_0001}};
      unit_ready = 1'b1;
      rsp_ready  = 1'b1;
      applyStimulus(4'b0001);

      // Reset values, with a request pending that must not be acknowledged.
      repeat (2) @(negedge clk);
      checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
      checkOutput("reset_busy", {31'b0, busy}, 32'd0);
      checkOutput("reset_unit_start", {31'b0, unit_start}, 32'd0);
      checkOutput("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      checkOutput("reset_rsp_id", 32'(rsp_id), 32'd0);
      checkOutput("reset_rsp_result", rsp_result, 32'd0);
      checkOutput("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
      checkOutput("reset_unit_ptr", unit_input_ptr, 32'd0);
      applyStimulus(4'b0000);
      @(posedge clk);
      #1 rst_n = 1'b1;

      $display("[TB] Test 1: single job from requester 0");
      rspQ.push_back('{id: 2'd0, result: 32'd1, err: 1'b0});
      startQ.push_back(32'h1000);
      @(posedge clk);
      #1 applyStimulus(4'b0001);
      #1 checkOutput("t1_req_ready", 32'(req_ready), 32'h1);
      @(posedge clk);
      #1 applyStimulus(4'b0000);
      checkOutput("t1_unit_start_latency", {31'b0, unit_start}, 32'd1);
      checkOutput("t1_unit_params", unit_params, 32'h0002_0001);
      waitIdle(100);
      checkOutput("t1_start_count", 32'(startCount), 32'd1);

      $display("[TB] Test 2: round-robin across all requesters");
      doReset();
      for (int i = 0; i < 5; i++) begin
         rspQ.push_back('{id: RID_W'((i % 4)), result: 32'((i % 4) + 1), err: 1'b0});
         startQ.push_back(32'h1000 * 32'((i % 4) + 1));
      end
      @(posedge clk);
      #1 applyStimulus(4'b1111);
      accepts = 0;
      n = 0;
      while (accepts < 5 && n < 500) begin
         @(negedge clk);
         n++;
         if ((req_ready & req_valid) != '0) begin
            checkOutput("t2_accept_order", 32'(req_ready), 32'(order[accepts]));
            accepts++;
         end
      end
      checkOutput("t2_accept_count", 32'(accepts), 32'd5);
      @(posedge clk);
      #1 applyStimulus(4'b0000);
      waitIdle(100);
      checkOutput("t2_start_count", 32'(startCount), 32'd6);

      $display("[TB] Test 3: response back-pressure");
      rsp_ready = 1'b0;
      rspQ.push_back('{id: 2'd2, result: 32'd3, err: 1'b0});
      rspQ.push_back('{id: 2'd3, result: 32'd4, err: 1'b0});
      startQ.push_back(32'h3000);
      startQ.push_back(32'h4000);
      @(posedge clk);
      #1 applyStimulus(4'b0100);
      #1 checkOutput("t3_req_ready", 32'(req_ready), 32'h4);
      @(posedge clk);
      #1 applyStimulus(4'b1011);
      waitRsp(100);
      for (int k = 0; k < 10; k++) begin
         checkOutput("t3_hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
         checkOutput("t3_hold_rsp_id", 32'(rsp_id), 32'd2);
         checkOutput("t3_hold_rsp_result", rsp_result, 32'd3);
         checkOutput("t3_hold_req_ready", 32'(req_ready), 32'd0);
         checkOutput("t3_hold_unit_start", {31'b0, unit_start}, 32'd0);
         @(negedge clk);
      end
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      @(posedge clk);
      #1 checkOutput("t3_resume_req_ready", 32'(req_ready), 32'h8);
      @(posedge clk);
      #1 applyStimulus(4'b0000);
      waitIdle(100);

      $display("[TB] Test 4: unit not ready while issuing");
      unit_ready = 1'b0;
      rspQ.push_back('{id: 2'd1, result: 32'd2, err: 1'b0});
      startQ.push_back(32'h2000);
      @(posedge clk);
      #1 applyStimulus(4'b0010);
      @(posedge clk);
      #1 applyStimulus(4'b0000);
      for (int k = 0; k < 20; k++) begin
         checkOutput("t4_no_start", {31'b0, unit_start}, 32'd0);
         checkOutput("t4_busy", {31'b0, busy}, 32'd1);
         @(posedge clk);
         #1;
      end
      unit_ready = 1'b1;
      #1 checkOutput("t4_start_on_ready", {31'b0, unit_start}, 32'd1);
      waitIdle(100);
      checkOutput("t4_start_count", 32'(startCount), 32'd9);

      $display("[TB] Test 5: reset while waiting for the unit");
      modelDelay = 8;
      startQ.push_back(32'h1000);
      @(posedge clk);
      #1 applyStimulus(4'b0001);
      @(posedge clk);
      #1 applyStimulus(4'b0000);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("t5_busy", {31'b0, busy}, 32'd0);
      checkOutput("t5_unit_start", {31'b0, unit_start}, 32'd0);
      checkOutput("t5_unit_ptr", unit_input_ptr, 32'd0);
      checkOutput("t5_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         checkOutput("t5_done_ignored_rsp", {31'b0, rsp_valid}, 32'd0);
         checkOutput("t5_done_ignored_busy", {31'b0, busy}, 32'd0);
      end
      @(posedge clk);
      #1 applyStimulus(4'b1111);
      #1 checkOutput("t5_pointer_reset", 32'(req_ready), 32'h1);
      applyStimulus(4'b0000);
      modelDelay = 5;

      $display("[TB] Test 6: unit never completes");
      modelRespond = 1'b0;
      startQ.push_back(32'h3000);
      @(posedge clk);
      #1 applyStimulus(4'b0100);
      @(posedge clk);
      #1 applyStimulus(4'b0000);
`ifdef MEAN_SCHED_TIMEOUT_EN
      rspQ.push_back('{id: 2'd2, result: 32'd0, err: 1'b1});
      n = 0;
      do begin
         @(posedge clk);
         #1 n++;
      end while (!rsp_valid && n < 200);
      checkOutput("t6_timeout_latency", 32'(n), 32'd17);
      waitIdle(20);
`else
      repeat (1000) @(posedge clk);
      #1;
      checkOutput("t6_still_waiting_busy", {31'b0, busy}, 32'd1);
      checkOutput("t6_still_waiting_rsp", {31'b0, rsp_valid}, 32'd0);
      doReset();
`endif
      modelRespond = 1'b1;

      repeat (3) @(negedge clk);
      checkOutput("total_start_count", 32'(startCount), 32'd11);
      checkOutput("rsp_queue_drained", 32'(rspQ.size()), 32'd0);
      checkOutput("start_queue_drained", 32'(startQ.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
